mlp_layer_sequencer: RTL and testbench
======================================

// Module: mlp_layer_sequencer
// PURPOSE
//  Time-multiplexes one signed multiply-accumulate datapath over every neuron of one
//  fully-connected MLP layer (768->200, 200->50, 50->10). For each neuron it walks the
//  input, weight and bias memories, accumulates the dot product, adds the bias,
//  applies optional ReLU with saturation, and writes one result word per neuron.
//  One instance is configured per layer; the top-level network FSM chains them.
// PARAMETERS
//  N_IN   768  inputs per neuron (layer fan-in)
//  N_OUT  200  neurons in the layer
//  DW     16   data/weight/bias/output width, signed two's complement
//  FRAC   8    fractional bits (Q7.8)
//  IAW    $clog2(N_IN)            input address width (derived)
//  NAW    $clog2(N_OUT)           neuron address width (derived)
//  ACC_W  2*DW+$clog2(N_IN)       accumulator width (derived, no internal overflow)
// PORTS
//  clk       in   1        clock, rising edge
//  reset     in   1        synchronous, active-high
//  start     in   1        begin layer; sampled only in IDLE
//  relu_en   in   1        1: clamp negative results to 0 (0 for the final layer)
//  busy      out  1        high from the cycle after start is accepted until done
//  done      out  1        one-cycle pulse after the last neuron is written
//  in_addr   out  IAW      input-vector read address
//  in_data   in   DW       input word, valid 1 cycle after in_addr
//  w_addr    out  NAW+IAW  weight read address = {neuron, i}
//  w_data    in   DW       weight word, valid 1 cycle after w_addr
//  b_addr    out  NAW      bias read address = current neuron
//  b_data    in   DW       bias word, valid 1 cycle after b_addr, held while b_addr is stable
//  out_we    out  1        output write strobe, one cycle per neuron
//  out_addr  out  NAW      output address (neuron index)
//  out_data  out  DW       saturated, optionally ReLU'd result
// BEHAVIOUR
//  Reset: state=IDLE; busy=done=out_we=0; all addresses, out_data, counters, acc=0.
//  States: IDLE -> MAC -> DRAIN -> BIAS -> WRITE -> (MAC for next neuron | DONE) -> IDLE.
//  IDLE: start=1 -> MAC with n=0, i=0, acc=0. start is ignored in every other state.
//  MAC (N_IN cycles): issue in_addr=i, w_addr={n,i}; i++ each cycle. From the 2nd MAC
//   cycle on, acc += sext(in_data*w_data), using the data that returns for address i-1.
//  DRAIN (1 cycle): accumulate the last product (i=N_IN-1).
//  BIAS (1 cycle): acc += sext(b_data) <<< FRAC. b_addr=n is stable for the whole neuron.
//  WRITE (1 cycle): out_we=1, out_addr=n, out_data=f(acc). acc and i clear. If n==N_OUT-1,
//   go to DONE; otherwise n++ and go to MAC.
//  DONE (1 cycle): done=1, busy=0; next cycle IDLE. A start in DONE is ignored.
//  Timing: N_IN+3 cycles per neuron. done is asserted exactly N_OUT*(N_IN+3)+1 cycles
//   after the start edge. Writes occur at start+1+k*(N_IN+3)+(N_IN+2), k=0..N_OUT-1.
//  f(acc): s = acc >>> FRAC (arithmetic shift, truncate toward -inf). Saturate to
//   [-2^(DW-1), 2^(DW-1)-1]. If relu_en and s<0, output 0. relu_en is sampled at start.
//  Product is a full 2*DW signed value. Because of ACC_W sizing, acc never wraps.
//  out_data holds its last value between writes. out_we is never asserted outside WRITE.
//  Reset mid-layer: abort on that edge, no further out_we, return to IDLE; a new start is
//   required.
//  Address counters never wrap past N_IN-1 or N_OUT-1. N_IN and N_OUT need not be
//   powers of two.
// STRUCTURE
//  mlp_pkg: DW, FRAC, typedef enum seq_state_t {IDLE,MAC,DRAIN,BIAS,WRITE,DONE},
//   function sat_relu(acc, relu_en) shared with other layer blocks.
//  Sub-module mlp_mac: registered signed multiply-accumulate with clr, en, bias_add
//   controls and an ACC_W output. The sequencer contains only the FSM, counters and
//   output stage.
// TESTING (bench uses N_IN=4, N_OUT=3, 1-cycle-latency behavioural ROM/RAM models)
//  1 all in=0x0100, w=0x0100, b=0, relu_en=1 -> 3 writes of 0x0400, addresses 0,1,2;
//    done 22 cycles after start.
//  2 in=0x0100, w=0xFF00 (-1.0), b=0x0080 -> pre-ReLU -3.5: relu_en=1 gives 0x0000;
//    relu_en=0 gives 0xFC80.
//  3 in=w=0x7FFF, b=0x7FFF -> 0x7FFF. in=0x7FFF, w=0x8000 -> 0x8000 (relu_en=0).
//  4 distinct w={n,i}-dependent weights, in=i+1 -> per-neuron outputs match a golden
//    model. Checks address ordering and the 1-cycle data alignment.
//  5 start pulsed again mid-layer and in DONE -> ignored: exactly 3 writes, one done.
//  6 reset asserted during neuron 1 MAC -> the next cycle is IDLE with all outputs 0 and no
//    out_we. A fresh start then completes normally, as in scenario 1.

Source files
------------

// File: rtl/mlp_pkg.sv
// -----------------------------------------------------------------------------
// mlp_pkg
// Shared definitions for the MLP layer blocks: data format (Q7.8, 16-bit
// signed), the layer-sequencer state encoding, and the output saturation /
// ReLU function used by every layer.
// No ports (package).
// -----------------------------------------------------------------------------
package mlp_pkg;

    localparam int DW    = 16;  // data / weight / bias / output width
    localparam int FRAC  = 8;   // fractional bits (Q7.8)
    localparam int SAT_W = 64;  // width callers sign-extend the accumulator to

    localparam logic signed [SAT_W-1:0] SAT_MAX = (64'sd1 <<< (DW - 1)) - 64'sd1;
    localparam logic signed [SAT_W-1:0] SAT_MIN = -(64'sd1 <<< (DW - 1));

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MAC   = 3'd1,
        DRAIN = 3'd2,
        BIAS  = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } seq_state_t;

    // Rescale a Q(2*FRAC) accumulator back to Q7.8 (arithmetic shift, so the
    // fraction truncates toward -inf), clamp to the DW-bit signed range, and
    // optionally force negative results to zero.
    function automatic logic [DW-1:0] sat_relu(input logic signed [SAT_W-1:0] acc,
                                               input logic                    relu_en);
        logic signed [SAT_W-1:0] s;
        s = acc >>> FRAC;
        if (relu_en && s[SAT_W-1])
            return '0;
        if (s > SAT_MAX)
            return {1'b0, {(DW-1){1'b1}}};
        if (s < SAT_MIN)
            return {1'b1, {(DW-1){1'b0}}};
        return s[DW-1:0];
    endfunction

endpackage

// File: rtl/mlp_mac.sv
// -----------------------------------------------------------------------------
// mlp_mac
// Registered signed multiply-accumulate. One product (or one scaled bias) is
// added per enabled cycle; the accumulator is wide enough that a full
// dot product of N_IN terms can never wrap.
// Ports:
//   clk       in   clock, rising edge
//   reset     in   synchronous active-high, clears the accumulator
//   clr       in   load zero (highest priority)
//   en        in   acc += a*b
//   bias_add  in   acc += bias <<< FRAC (takes priority over en)
//   a, b      in   DW-bit signed operands
//   bias      in   DW-bit signed bias in Q7.8
//   acc       out  ACC_W-bit signed accumulator
// -----------------------------------------------------------------------------
module mlp_mac
    import mlp_pkg::*;
#(
    parameter int ACC_W = 2 * DW + 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clr,
    input  logic                    en,
    input  logic                    bias_add,
    input  logic signed [DW-1:0]    a,
    input  logic signed [DW-1:0]    b,
    input  logic signed [DW-1:0]    bias,
    output logic signed [ACC_W-1:0] acc
);

    logic signed [2*DW-1:0]  w_prod;
    logic signed [ACC_W-1:0] w_prod_ext;
    logic signed [ACC_W-1:0] w_bias_ext;
    logic signed [ACC_W-1:0] r_acc;

    assign w_prod     = a * b;
    assign w_prod_ext = {{(ACC_W-2*DW){w_prod[2*DW-1]}}, w_prod};
    // Bias is Q7.8 while products are Q14.16, so align it before adding.
    assign w_bias_ext = {{(ACC_W-DW){bias[DW-1]}}, bias} <<< FRAC;

    always_ff @(posedge clk) begin
        if (reset || clr)
            r_acc <= '0;
        else if (bias_add)
            r_acc <= r_acc + w_bias_ext;
        else if (en)
            r_acc <= r_acc + w_prod_ext;
    end

    assign acc = r_acc;

endmodule

// File: rtl/mlp_layer_sequencer.sv
// -----------------------------------------------------------------------------
// mlp_layer_sequencer
// Runs one fully-connected layer through a single MAC: for each neuron n it
// streams inputs i=0..N_IN-1 with weights {n,i}, adds the bias, then writes
// sat_relu(acc) to output address n. N_IN+3 cycles per neuron.
// Ports:
//   clk, reset         clock / synchronous active-high reset
//   start, relu_en     begin a layer (IDLE only); ReLU select, captured at start
//   busy, done         layer in progress / one-cycle completion pulse
//   in_addr, in_data   input-vector memory (1-cycle read latency)
//   w_addr, w_data     weight memory, address {neuron, i} (1-cycle latency)
//   b_addr, b_data     bias memory, address = neuron (1-cycle latency)
//   out_we, out_addr, out_data   result write port, one strobe per neuron
// -----------------------------------------------------------------------------
module mlp_layer_sequencer
    import mlp_pkg::*;
#(
    parameter int N_IN  = 768,
    parameter int N_OUT = 200,
    parameter int IAW   = $clog2(N_IN),
    parameter int NAW   = $clog2(N_OUT),
    parameter int ACC_W = 2 * DW + $clog2(N_IN)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               relu_en,
    output logic               busy,
    output logic               done,
    output logic [IAW-1:0]     in_addr,
    input  logic [DW-1:0]      in_data,
    output logic [NAW+IAW-1:0] w_addr,
    input  logic [DW-1:0]      w_data,
    output logic [NAW-1:0]     b_addr,
    input  logic [DW-1:0]      b_data,
    output logic               out_we,
    output logic [NAW-1:0]     out_addr,
    output logic [DW-1:0]      out_data
);

    localparam logic [IAW-1:0] I_LAST = IAW'(N_IN - 1);
    localparam logic [NAW-1:0] N_LAST = NAW'(N_OUT - 1);

    seq_state_t              r_state;
    logic [IAW-1:0]          r_i;
    logic [NAW-1:0]          r_n;
    logic                    r_relu;
    logic [DW-1:0]           r_out;

    logic                    w_clr;
    logic                    w_en;
    logic                    w_bias_add;
    logic signed [ACC_W-1:0] w_acc;
    logic signed [SAT_W-1:0] w_acc_ext;
    logic [DW-1:0]           w_res;

    // Memory data returned this cycle belongs to the address issued last
    // cycle, so the first MAC cycle has nothing to add and DRAIN adds the
    // final term.
    assign w_clr      = (r_state == IDLE && start) || (r_state == WRITE);
    assign w_en       = (r_state == MAC && r_i != '0) || (r_state == DRAIN);
    assign w_bias_add = (r_state == BIAS);

    mlp_mac #(.ACC_W(ACC_W)) u_mac (
        .clk      (clk),
        .reset    (reset),
        .clr      (w_clr),
        .en       (w_en),
        .bias_add (w_bias_add),
        .a        (in_data),
        .b        (w_data),
        .bias     (b_data),
        .acc      (w_acc)
    );

    assign w_acc_ext = {{(SAT_W-ACC_W){w_acc[ACC_W-1]}}, w_acc};
    assign w_res     = sat_relu(w_acc_ext, r_relu);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_i     <= '0;
            r_n     <= '0;
            r_relu  <= 1'b0;
            r_out   <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= MAC;
                        r_i     <= '0;
                        r_n     <= '0;
                        r_relu  <= relu_en;
                    end
                end
                MAC: begin
                    // i stays at N_IN-1 through DRAIN/BIAS instead of wrapping
                    if (r_i == I_LAST)
                        r_state <= DRAIN;
                    else
                        r_i <= r_i + IAW'(1);
                end
                DRAIN: r_state <= BIAS;
                BIAS:  r_state <= WRITE;
                WRITE: begin
                    r_out <= w_res;
                    r_i   <= '0;
                    if (r_n == N_LAST) begin
                        r_state <= DONE;
                    end else begin
                        r_n     <= r_n + NAW'(1);
                        r_state <= MAC;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy     = (r_state != IDLE) && (r_state != DONE);
    assign done     = (r_state == DONE);
    assign in_addr  = r_i;
    assign w_addr   = {r_n, r_i};
    assign b_addr   = r_n;
    assign out_we   = (r_state == WRITE);
    assign out_addr = r_n;
    // Present the fresh result during WRITE, otherwise hold the last one.
    assign out_data = out_we ? w_res : r_out;

endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mlp_layer_sequencer
// Directed bench for a 4-input, 3-neuron layer with 1-cycle-latency memory
// models. Stimulus pushes expected writes into a queue; a monitor pops and
// compares each out_we cycle.
// -----------------------------------------------------------------------------
module tb_mlp_layer_sequencer;

    localparam int N_IN  = 4;
    localparam int N_OUT = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        relu_en;
    logic        busy;
    logic        done;
    logic [1:0]  in_addr;
    logic [15:0] in_data;
    logic [3:0]  w_addr;
    logic [15:0] w_data;
    logic [1:0]  b_addr;
    logic [15:0] b_data;
    logic        out_we;
    logic [1:0]  out_addr;
    logic [15:0] out_data;

    logic [15:0] in_mem [N_IN];
    logic [15:0] w_mem  [N_IN*N_OUT+4];
    logic [15:0] b_mem  [4];

    typedef struct {
        logic [1:0]  addr;
        logic [15:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   errors   = 0;
    int   checks   = 0;
    int   done_cnt = 0;

    mlp_layer_sequencer #(.N_IN(N_IN), .N_OUT(N_OUT)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .relu_en  (relu_en),
        .busy     (busy),
        .done     (done),
        .in_addr  (in_addr),
        .in_data  (in_data),
        .w_addr   (w_addr),
        .w_data   (w_data),
        .b_addr   (b_addr),
        .b_data   (b_data),
        .out_we   (out_we),
        .out_addr (out_addr),
        .out_data (out_data)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory models
    always @(posedge clk) begin
        in_data <= in_mem[in_addr];
        w_data  <= w_mem[w_addr];
        b_data  <= b_mem[b_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write must match the head of the scoreboard
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (out_we) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %0d data 0x%0h, expected no write", out_addr, out_data);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("out_addr", 32'(out_addr), 32'(e.addr));
                check("out_data", 32'(out_data), 32'(e.data));
            end
        end
    end

    task automatic fill(input logic [15:0] inv, input logic [15:0] wv, input logic [15:0] bv);
        for (int k = 0; k < N_IN; k++) in_mem[k] = inv;
        for (int k = 0; k < N_IN*N_OUT+4; k++) w_mem[k] = wv;
        for (int k = 0; k < 4; k++) b_mem[k] = bv;
    endtask

    task automatic expect3(input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2);
        exp_t e;
        e.addr = 2'd0; e.data = e0; sb_q.push_back(e);
        e.addr = 2'd1; e.data = e1; sb_q.push_back(e);
        e.addr = 2'd2; e.data = e2; sb_q.push_back(e);
    endtask

    // Runs one layer from a negedge; optional extra start mid-layer and in DONE.
    task automatic run_layer(input string name, input logic relu, input int mid_start,
                             input logic start_in_done);
        int cnt;
        int d0;
        d0      = done_cnt;
        start   = 1'b1;
        relu_en = relu;
        for (cnt = 1; cnt <= 100; cnt++) begin
            @(negedge clk);
            start   = 1'b0;
            relu_en = ~relu;
            if (cnt == mid_start) start = 1'b1;
            if (done) begin
                if (start_in_done) start = 1'b1;
                break;
            end
        end
        check({name, "_done_latency"}, 32'(cnt), 32'd22);
        @(negedge clk);
        start = 1'b0;
        check({name, "_busy_after"}, 32'(busy), 32'd0);
        repeat (4) @(negedge clk);
        check({name, "_busy_idle"}, 32'(busy), 32'd0);
        check({name, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
        check({name, "_writes_left"}, 32'(sb_q.size()), 32'd0);
        sb_q.delete();
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        relu_en = 1'b0;
        fill(16'h0000, 16'h0000, 16'h0000);
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_out_we", 32'(out_we), 32'd0);
        check("rst_addrs", {in_addr, w_addr, b_addr, out_addr}, 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // 1: 1.0 * 1.0 over 4 inputs = 4.0
        fill(16'h0100, 16'h0100, 16'h0000);
        expect3(16'h0400, 16'h0400, 16'h0400);
        run_layer("s1", 1'b1, 0, 1'b0);

        // 2: 4 * (-1.0) + 0.5 = -3.5
        fill(16'h0100, 16'hFF00, 16'h0080);
        expect3(16'h0000, 16'h0000, 16'h0000);
        run_layer("s2_relu", 1'b1, 0, 1'b0);
        expect3(16'hFC80, 16'hFC80, 16'hFC80);
        run_layer("s2_norelu", 1'b0, 0, 1'b0);

        // 3: saturation both ways
        fill(16'h7FFF, 16'h7FFF, 16'h7FFF);
        expect3(16'h7FFF, 16'h7FFF, 16'h7FFF);
        run_layer("s3_pos", 1'b1, 0, 1'b0);
        fill(16'h7FFF, 16'h8000, 16'h0000);
        expect3(16'h8000, 16'h8000, 16'h8000);
        run_layer("s3_neg", 1'b0, 0, 1'b0);

        // 4: in = i+1 (Q7.8), w{n,i} = (4n+i-5)/4, b = {0.5, 1.0, 2.0}
        //   n0: -30/4 + 0.5 = -7.0 -> 0xF900
        //   n1:  10/4 + 1.0 =  3.5 -> 0x0380
        //   n2:  50/4 + 2.0 = 14.5 -> 0x0E80
        for (int i = 0; i < N_IN; i++) in_mem[i] = 16'((i + 1) * 256);
        for (int n = 0; n < N_OUT; n++)
            for (int i = 0; i < N_IN; i++)
                w_mem[n*4 + i] = 16'((4*n + i - 5) * 64);
        b_mem[0] = 16'h0080;
        b_mem[1] = 16'h0100;
        b_mem[2] = 16'h0200;
        expect3(16'hF900, 16'h0380, 16'h0E80);
        run_layer("s4", 1'b0, 0, 1'b0);

        // 5: start pulsed mid-layer and during DONE is ignored
        fill(16'h0100, 16'h0100, 16'h0000);
        expect3(16'h0400, 16'h0400, 16'h0400);
        run_layer("s5", 1'b1, 8, 1'b1);

        // 6: reset during neuron 1 MAC
        expect3(16'h0400, 16'h0400, 16'h0400);
        start   = 1'b1;
        relu_en = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        check("s6_busy", 32'(busy), 32'd0);
        check("s6_done", 32'(done), 32'd0);
        check("s6_out_we", 32'(out_we), 32'd0);
        check("s6_addrs", {in_addr, w_addr, b_addr, out_addr}, 32'd0);
        check("s6_out_data", 32'(out_data), 32'd0);
        reset = 1'b0;
        check("s6_pending", 32'(sb_q.size()), 32'd2);
        sb_q.delete();
        repeat (30) @(negedge clk);
        check("s6_still_idle", 32'(busy), 32'd0);
        expect3(16'h0400, 16'h0400, 16'h0400);
        run_layer("s6_restart", 1'b1, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
